// File: rtl/mem_store_pkg.sv
// Shared types and helpers for the MEM-stage store unit.
package mem_store_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        MERGE = 2'd2,
        WRITE = 2'd3
    } st_state_t;

    localparam logic SZ_WORD = 1'b0;
    localparam logic SZ_HALF = 1'b1;

    // Half-word stores need 2-byte alignment, word stores need 4-byte alignment.
    function automatic logic is_misaligned(input logic half, input logic [1:0] lsb);
        return (half == SZ_HALF) ? lsb[0] : (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/half_insert.sv
// Replaces one 16-bit lane of a 32-bit word; sel_hi=1 targets bits [31:16].
module half_insert (
    input  logic [31:0] word_in,
    input  logic [15:0] half_in,
    input  logic        sel_hi,
    output logic [31:0] word_out
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        // Lane 1 is the upper half, lane 0 the lower half.
        logic lane_sel;
        assign lane_sel = (gi == 1) ? sel_hi : ~sel_hi;
        assign word_out[16*gi +: 16] = lane_sel ? half_in : word_in[16*gi +: 16];
    end

endmodule

// File: rtl/store_half_merge.sv
// MEM-stage store unit: word stores write straight through, half-word
// stores do a read-modify-write on a memory without byte enables.
module store_half_merge
    import mem_store_pkg::*;
#(
    parameter int MEM_AW     = 16,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_half,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata
);

    localparam logic BE_BIT = (BIG_ENDIAN != 0);

    st_state_t         state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              sel_hi_q, sel_hi_d;
    logic [31:0]       merge_q, merge_d;
    logic              misaligned_q, misaligned_d;

    logic              req_bad;
    logic              accept;
    logic [31:0]       inserted;

    // Only the word-address bits reach memory; the rest of the byte address is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr};

    assign req_bad = is_misaligned(req_half, req_addr[1:0]);
    assign accept  = (state_q == IDLE) && req_valid && !req_bad;

    half_insert u_half_insert (
        .word_in  (mem_rdata),
        .half_in  (data_q),
        .sel_hi   (sel_hi_q),
        .word_out (inserted)
    );

    // Next-state and datapath-register updates for the store FSM.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        sel_hi_d     = sel_hi_q;
        merge_d      = merge_q;
        misaligned_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        misaligned_d = 1'b1;
                    end else begin
                        addr_d   = req_addr[MEM_AW+1:2];
                        data_d   = req_data[15:0];
                        sel_hi_d = req_addr[1] ^ BE_BIT;
                        // Word stores carry their data straight to the write cycle.
                        merge_d  = req_data;
                        state_d  = (req_half == SZ_HALF) ? READ : WRITE;
                    end
                end
            end
            READ:    state_d = MERGE;
            MERGE: begin
                merge_d = inserted;
                state_d = WRITE;
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            sel_hi_q     <= 1'b0;
            merge_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            sel_hi_q     <= sel_hi_d;
            merge_q      <= merge_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Strobes decode directly from the state register so they are glitch-free
    // and read/write can never overlap.
    assign mem_rd_en  = (state_q == READ);
    assign mem_wr_en  = (state_q == WRITE);
    assign done       = (state_q == WRITE);
    assign misaligned = misaligned_q;
    assign busy       = (state_q != IDLE) || accept;
    assign mem_addr   = addr_q;
    assign mem_wdata  = merge_q;

endmodule

// File: tb/tb_store_half_merge.sv
// Bench for store_half_merge: a little-endian and a big-endian instance run in
// lockstep, each with its own synchronous memory, against a reference model.
module tb_store_half_merge;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_half  = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_data  = '0;

    logic          pre_we   = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = '0;

    logic          busy_w  [2];
    logic          done_w  [2];
    logic          mis_w   [2];
    logic          rd_w    [2];
    logic          wr_w    [2];
    logic [AW-1:0] maddr_w [2];
    logic [31:0]   wdata_w [2];

    logic [31:0] ref_mem [2][DEPTH];
    int tests = 0;
    int fails = 0;
    bit just_done = 1'b0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [31:0] mem [DEPTH];
        logic [31:0] rdata;
        int overlap = 0;

        store_half_merge #(.MEM_AW(AW), .BIG_ENDIAN(gi)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid),
            .req_half   (req_half),
            .req_addr   (req_addr),
            .req_data   (req_data),
            .busy       (busy_w[gi]),
            .done       (done_w[gi]),
            .misaligned (mis_w[gi]),
            .mem_addr   (maddr_w[gi]),
            .mem_rd_en  (rd_w[gi]),
            .mem_rdata  (rdata),
            .mem_wr_en  (wr_w[gi]),
            .mem_wdata  (wdata_w[gi])
        );

        always @(posedge clk) begin
            if (pre_we) mem[pre_addr] <= pre_data;
            else if (wr_w[gi]) mem[maddr_w[gi]] <= wdata_w[gi];
            if (rd_w[gi]) rdata <= mem[maddr_w[gi]];
        end

        always @(negedge clk) if (rd_w[gi] && wr_w[gi]) overlap++;
    end

    function automatic logic [31:0] mem_word(input int i, input int w);
        return (i == 0) ? g_dut[0].mem[w] : g_dut[1].mem[w];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_busy"},  busy_w[i], 0);
            check({tag, "_done"},  done_w[i], 0);
            check({tag, "_mis"},   mis_w[i], 0);
            check({tag, "_rd"},    rd_w[i], 0);
            check({tag, "_wr"},    wr_w[i], 0);
            check({tag, "_addr"},  maddr_w[i], 0);
            check({tag, "_wdata"}, wdata_w[i], 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        just_done = 1'b0;
    endtask

    // Writes a word into both memories behind the DUTs' backs (DUTs idle).
    task automatic preload_word(input int w, input logic [31:0] val);
        pre_we   = 1'b1;
        pre_addr = AW'(w);
        pre_data = val;
        ref_mem[0][w] = val;
        ref_mem[1][w] = val;
        @(negedge clk);
        pre_we = 1'b0;
        just_done = 1'b0;
    endtask

    // Presents one store at the current negedge and follows it to completion.
    task automatic do_store(input logic half, input logic [31:0] addr,
                            input logic [31:0] data, input int txn);
        bit          bad;
        int          w, lane, k, exp_lat;
        logic [31:0] mask;
        logic [31:0] expv [2];
        int          lat [2];
        int          rds [2];
        logic [31:0] wd_at [2];
        logic [31:0] ad_at [2];
        bit          seen [2];

        bad = half ? (addr % 2 != 0) : (addr % 4 != 0);
        w   = (addr / 4) % DEPTH;
        for (int i = 0; i < 2; i++) begin
            if (!half) begin
                expv[i] = data;
            end else begin
                lane    = ((addr / 2) % 2) ^ i;
                mask    = 32'hFFFF << (16 * lane);
                expv[i] = (ref_mem[i][w] & ~mask) | ((data & 32'hFFFF) << (16 * lane));
            end
        end
        exp_lat = (half ? 3 : 1) + (just_done ? 1 : 0);

        req_valid = 1'b1;
        req_half  = half;
        req_addr  = addr;
        req_data  = data;
        #1;
        for (int i = 0; i < 2; i++) check("accept_busy", busy_w[i], !bad);

        if (bad) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("mis_pulse", mis_w[i], 1);
                check("mis_rd", rd_w[i], 0);
                check("mis_wr", wr_w[i], 0);
            end
            req_valid = 1'b0;
            #1;
            for (int i = 0; i < 2; i++) check("mis_busy", busy_w[i], 0);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("mis_clear", mis_w[i], 0);
                check("mis_rd2", rd_w[i], 0);
                check("mis_wr2", wr_w[i], 0);
            end
            just_done = 1'b0;
            $display("[TB] txn %0d %s addr=0x%08h data=0x%08h rejected misaligned",
                     txn, half ? "half" : "word", addr, data);
            return;
        end

        k = 0;
        for (int i = 0; i < 2; i++) begin
            lat[i] = 99; rds[i] = 0; seen[i] = 1'b0; wd_at[i] = '0; ad_at[i] = '0;
        end
        while (!(seen[0] && seen[1]) && k < 8) begin
            @(negedge clk);
            k++;
            for (int i = 0; i < 2; i++) begin
                if (!seen[i]) begin
                    if (rd_w[i]) rds[i]++;
                    if (done_w[i]) begin
                        seen[i]  = 1'b1;
                        lat[i]   = k;
                        wd_at[i] = wdata_w[i];
                        ad_at[i] = 32'(maddr_w[i]);
                        check("done_wr", wr_w[i], 1);
                    end
                end
            end
        end
        req_valid = 1'b0;

        for (int i = 0; i < 2; i++) begin
            check("latency", lat[i], exp_lat);
            check("rd_count", rds[i], half ? 1 : 0);
            check("wr_addr", ad_at[i], w);
            check("wdata", wd_at[i], expv[i]);
            if (seen[i]) ref_mem[i][w] = expv[i];
        end
        just_done = 1'b1;
        $display("[TB] txn %0d %s addr=0x%08h data=0x%08h le=0x%08h be=0x%08h lat=%0d",
                 txn, half ? "half" : "word", addr, data, wd_at[0], wd_at[1], lat[0]);
    endtask

    initial begin
        int bad_words;
        bit          rh;
        int          rw, gap;
        logic [1:0]  lsb;
        logic [31:0] ra, rdat;

        // Reset and memory preload.
        #1;
        check_idle_outputs("reset");
        for (int w = 0; w < DEPTH; w++) preload_word(w, (w == 4) ? 32'h1122_3344 : $urandom);
        #1;
        check_idle_outputs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check_idle_outputs("post_reset");

        // Word store.
        do_store(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1);
        idle(1);
        check("word_mem_le", mem_word(0, 4), 32'hDEAD_BEEF);
        check("word_mem_be", mem_word(1, 4), 32'hDEAD_BEEF);

        // Half store, lower address.
        preload_word(4, 32'h1122_3344);
        do_store(1'b1, 32'h0000_0010, 32'h0000_ABCD, 2);
        idle(1);
        check("half_lo_le", mem_word(0, 4), 32'h1122_ABCD);
        check("half_lo_be", mem_word(1, 4), 32'hABCD_3344);

        // Half store, upper address.
        preload_word(4, 32'h1122_3344);
        do_store(1'b1, 32'h0000_0012, 32'hFFFF_5566, 3);
        idle(1);
        check("half_hi_le", mem_word(0, 4), 32'h5566_3344);
        check("half_hi_be", mem_word(1, 4), 32'h1122_5566);

        // Misaligned requests.
        do_store(1'b1, 32'h0000_0011, 32'h0000_1234, 4);
        do_store(1'b0, 32'h0000_0012, 32'h5555_6666, 5);

        // Back-to-back half stores to one word.
        preload_word(4, 32'h0000_0000);
        do_store(1'b1, 32'h0000_0010, 32'h0000_AAAA, 6);
        do_store(1'b1, 32'h0000_0012, 32'h0000_BBBB, 7);
        idle(1);
        check("b2b_le", mem_word(0, 4), 32'hBBBB_AAAA);
        check("b2b_be", mem_word(1, 4), 32'hAAAA_BBBB);

        // Reset during MERGE abandons the store.
        req_valid = 1'b1; req_half = 1'b1; req_addr = 32'h10; req_data = 32'h0000_1234;
        @(negedge clk);
        for (int i = 0; i < 2; i++) check("rst_read_rd", rd_w[i], 1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_merge_busy", busy_w[i], 1);
            check("rst_merge_rd", rd_w[i], 0);
        end
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check_idle_outputs("midop_reset");
        idle(2);
        check("rst_mem_le", mem_word(0, 4), ref_mem[0][4]);
        check("rst_mem_be", mem_word(1, 4), ref_mem[1][4]);
        rst_n = 1'b1;
        idle(1);
        do_store(1'b1, 32'h0000_0012, 32'h0000_7788, 8);
        idle(1);

        // Randomized traffic over a small address window to force collisions.
        for (int t = 0; t < 60; t++) begin
            rh   = 1'($urandom_range(0, 1));
            rw   = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) lsb = 2'($urandom_range(0, 3));
            else lsb = rh ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            ra   = ($urandom & 32'hFFFF_FC00) | 32'(rw << 2) | 32'(lsb);
            rdat = $urandom;
            gap  = $urandom_range(0, 2);
            if ((rh && lsb[0]) || (!rh && lsb != 2'b00)) begin
                if (gap == 0) gap = 1;
            end
            if (gap > 0) idle(gap);
            do_store(rh, ra, rdat, 100 + t);
        end
        idle(2);

        // Whole-memory comparison and read/write exclusivity.
        for (int i = 0; i < 2; i++) begin
            bad_words = 0;
            for (int w = 0; w < DEPTH; w++) if (mem_word(i, w) !== ref_mem[i][w]) bad_words++;
            check("mem_final", bad_words, 0);
        end
        check("rd_wr_overlap_le", g_dut[0].overlap, 0);
        check("rd_wr_overlap_be", g_dut[1].overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
